// File: rtl/ascon_job_arbiter.sv
// Round-robin front end for a single shared ASCON AEAD engine.
// It accepts one 32-bit job at a time, runs it on the engine under a watchdog, and returns the result to the requester.
module ascon_job_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*32-1:0]   req_data,
    input  logic [NREQ*160-1:0]  req_ct,
    input  logic [NREQ*128-1:0]  req_nonce,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          resp_data,
    output logic [127:0]         resp_tag,
    output logic [127:0]         resp_nonce,
    output logic [1:0]           resp_status,
    input  logic                 nonce_load,
    input  logic [127:0]         nonce_init,
    output logic                 nonce_exhausted,
    output logic                 busy,
    output logic                 eng_en,
    output logic                 eng_enc_start,
    output logic                 eng_dec_start,
    output logic [127:0]         eng_nonce,
    output logic [31:0]          eng_pt,
    output logic [159:0]         eng_ct,
    input  logic                 eng_done,
    input  logic [31:0]          eng_out,
    input  logic [127:0]         eng_tag,
    input  logic                 eng_auth_fail
);
    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(RECOVER_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RECOVER, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  last_grant_q, last_grant_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic           job_op_q, job_op_d;
    logic [127:0]   nonce_q, nonce_d;
    logic [31:0]    pt_q, pt_d;
    logic [159:0]   ct_q, ct_d;
    logic [127:0]   ctr_q, ctr_d;
    logic           exh_q, exh_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [RW-1:0]  rec_q, rec_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [127:0]   rtag_q, rtag_d;
    logic [1:0]     rstat_q, rstat_d;

    logic           win_found;
    int             win_i;
    logic [GW-1:0]  win_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            grant_q      <= '0;
            job_op_q     <= 1'b0;
            nonce_q      <= '0;
            pt_q         <= '0;
            ct_q         <= '0;
            ctr_q        <= '0;
            exh_q        <= 1'b0;
            timer_q      <= '0;
            rec_q        <= '0;
            rdata_q      <= '0;
            rtag_q       <= '0;
            rstat_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            job_op_q     <= job_op_d;
            nonce_q      <= nonce_d;
            pt_q         <= pt_d;
            ct_q         <= ct_d;
            ctr_q        <= ctr_d;
            exh_q        <= exh_d;
            timer_q      <= timer_d;
            rec_q        <= rec_d;
            rdata_q      <= rdata_d;
            rtag_q       <= rtag_d;
            rstat_q      <= rstat_d;
        end
    end

    // Rotating priority: search starts just after the last requester served.
    always_comb begin
        win_found = 1'b0;
        win_i     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_i     = (int'(last_grant_q) + k) % NREQ;
            end
        end
    end
    assign win_idx = win_i[GW-1:0];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        job_op_d     = job_op_q;
        nonce_d      = nonce_q;
        pt_d         = pt_q;
        ct_d         = ct_q;
        ctr_d        = ctr_q;
        exh_d        = exh_q;
        timer_d      = timer_q;
        rec_d        = rec_q;
        rdata_d      = rdata_q;
        rtag_d       = rtag_q;
        rstat_d      = rstat_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d  = win_idx;
                    job_op_d = req_op[win_idx];
                    pt_d     = req_data[win_i*32 +: 32];
                    ct_d     = req_ct[win_i*160 +: 160];
                    if (req_op[win_idx]) begin
                        nonce_d = req_nonce[win_i*128 +: 128];
                        state_d = S_LAUNCH;
                    end else if (exh_q) begin
                        // Counter already wrapped: refuse to reuse a nonce.
                        nonce_d = ctr_q;
                        rdata_d = '0;
                        rtag_d  = '0;
                        rstat_d = 2'b11;
                        state_d = S_RESP;
                    end else begin
                        nonce_d = ctr_q;
                        ctr_d   = ctr_q + 128'd1;
                        if (&ctr_q) exh_d = 1'b1;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    rdata_d = (job_op_q && eng_auth_fail) ? 32'd0 : eng_out;
                    rtag_d  = job_op_q ? 128'd0 : eng_tag;
                    rstat_d = (job_op_q && eng_auth_fail) ? 2'b01 : 2'b00;
                    state_d = S_RESP;
                end else if (timer_q == T_LAST) begin
                    rec_d   = '0;
                    state_d = S_RECOVER;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RECOVER: begin
                if (rec_q == R_LAST) begin
                    rdata_d = '0;
                    rtag_d  = '0;
                    rstat_d = 2'b10;
                    state_d = S_RESP;
                end else begin
                    rec_d = rec_q + 1'b1;
                end
            end
            S_RESP: begin
                if (resp_ready[grant_q]) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A load wins over the accept-time increment; the job keeps the old value.
        if (nonce_load) begin
            ctr_d = nonce_init;
            exh_d = 1'b0;
        end
    end

    always_comb begin
        req_ready     = '0;
        resp_valid    = '0;
        eng_en        = 1'b0;
        eng_enc_start = 1'b0;
        eng_dec_start = 1'b0;
        busy          = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:   req_ready[win_idx] = win_found;
            S_LAUNCH: begin
                eng_en        = 1'b1;
                eng_enc_start = !job_op_q;
                eng_dec_start = job_op_q;
            end
            S_WAIT:   eng_en = 1'b1;
            S_RESP:   resp_valid[grant_q] = 1'b1;
            default:  ;
        endcase
    end

    assign eng_nonce       = nonce_q;
    assign eng_pt          = pt_q;
    assign eng_ct          = ct_q;
    assign resp_nonce      = nonce_q;
    assign resp_data       = rdata_q;
    assign resp_tag        = rtag_q;
    assign resp_status     = rstat_q;
    assign nonce_exhausted = exh_q;

endmodule
